uart_echo_checker: RTL and testbench

- Initiator side of the UART echo loop: drives a known byte sequence into the team's `uart` core transmit interface and checks every byte echoed back on its receive interface.
- The far end is a board running the echo design (received byte retransmitted unchanged), or a physical rx-tx jumper.
- Reports pass/fail, error count and progress for board bring-up and regression of the `uart` core.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_pattern_gen.sv | 47 ++++
 rtl/uart_echo_checker.sv | 152 +++++++++++++++
 tb/tb_uart_echo_checker.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART echo checker.
// Optional macro UART_ECHO_LFSR_EN selects the LFSR pattern in uart_pattern_gen.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_IDLE,
    SEND,
    WAIT_ECHO,
    NEXT,
    DONE
  } state_t;

  localparam logic [7:0] ERR_MAX   = 8'hFF;
  // x^8+x^6+x^5+x^4+1: taps on bits 7,5,4,3 of a left-shifting register
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] lfsr_next(input logic [7:0] p);
    return {p[6:0], ^(p & LFSR_TAPS)};
  endfunction

  // A zero seed would lock the LFSR, so it is replaced by 1
  function automatic logic [7:0] lfsr_seed(input logic [7:0] s);
    return (s == 8'h00) ? 8'h01 : s;
  endfunction

endpackage

// File: rtl/uart_pattern_gen.sv
// Test-pattern source for the echo checker.
// Macro UART_ECHO_LFSR_EN: defined -> 8-bit Fibonacci LFSR, undefined -> +1 counter.
module uart_pattern_gen
  import uart_pkg::*;
#(
  parameter logic [7:0] SEED = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       advance,
  input  logic [7:0] seed,
  output logic [7:0] pattern
);

`ifdef UART_ECHO_LFSR_EN
  localparam logic [7:0] RESET_VAL = lfsr_seed(SEED);
`else
  localparam logic [7:0] RESET_VAL = SEED;
`endif

  logic [7:0] load_val;
  logic [7:0] next_val;

  // Value taken on load and successor of the current pattern
  always_comb begin
`ifdef UART_ECHO_LFSR_EN
    load_val = lfsr_seed(seed);
    next_val = lfsr_next(pattern);
`else
    load_val = seed;
    next_val = pattern + 8'd1;
`endif
  end

  // Pattern register: load has priority over advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pattern <= RESET_VAL;
    end else if (load) begin
      pattern <= load_val;
    end else if (advance) begin
      pattern <= next_val;
    end
  end

endmodule

// File: rtl/uart_echo_checker.sv
// UART echo loop initiator: sends a pattern through the uart core and checks
// every echoed byte, reporting pass/fail, error count and progress.
// Macro UART_ECHO_LFSR_EN (see uart_pattern_gen) selects the LFSR pattern.
module uart_echo_checker
  import uart_pkg::*;
#(
  parameter int unsigned NUM_BYTES      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 200000,
  parameter logic [7:0]  SEED           = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [7:0]  tx_byte,
  output logic        transmit,
  input  logic        is_transmitting,
  input  logic [7:0]  rx_byte,
  input  logic        received,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [7:0]  err_count,
  output logic [15:0] bytes_done
);

  localparam int unsigned   TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LOAD  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0]   LAST_IDX = 16'(NUM_BYTES - 1);

  state_t        state;
  state_t        state_nxt;
  logic [7:0]    pattern;
  logic          pat_load;
  logic          pat_adv;
  logic [TW-1:0] to_cnt;
  logic          err_inc;

  uart_pattern_gen #(
    .SEED (SEED)
  ) u_pattern (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (pat_load),
    .advance (pat_adv),
    .seed    (SEED),
    .pattern (pattern)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic, pattern control and strobes
  always_comb begin
    state_nxt = state;
    pat_load  = 1'b0;
    pat_adv   = 1'b0;
    err_inc   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          pat_load  = 1'b1;
          state_nxt = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (!is_transmitting) begin
          state_nxt = SEND;
        end
      end
      SEND: begin
        state_nxt = WAIT_ECHO;
      end
      WAIT_ECHO: begin
        // an echo arriving on the expiry cycle still wins over the timeout
        if (received) begin
          err_inc   = (rx_byte != pattern);
          state_nxt = NEXT;
        end else if (to_cnt == '0) begin
          err_inc   = 1'b1;
          state_nxt = NEXT;
        end
      end
      NEXT: begin
        pat_adv   = 1'b1;
        state_nxt = (bytes_done == LAST_IDX) ? DONE : WAIT_IDLE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign transmit = (state == SEND);
  assign done     = (state == DONE);
  assign busy     = (state != IDLE) && (state != DONE);

  // Transmit byte, timeout counter and run statistics
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_byte    <= '0;
      to_cnt     <= '0;
      err_count  <= '0;
      bytes_done <= '0;
      pass       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            err_count  <= '0;
            bytes_done <= '0;
            pass       <= 1'b0;
          end
        end
        WAIT_IDLE: begin
          // latched one cycle early so tx_byte is valid with transmit and holds after
          if (!is_transmitting) begin
            tx_byte <= pattern;
          end
        end
        SEND: begin
          to_cnt <= TO_LOAD;
        end
        WAIT_ECHO: begin
          if (!received && to_cnt != '0) begin
            to_cnt <= to_cnt - 1'b1;
          end
          if (err_inc && err_count != ERR_MAX) begin
            err_count <= err_count + 8'd1;
          end
        end
        NEXT: begin
          bytes_done <= bytes_done + 16'd1;
        end
        DONE: begin
          pass <= (err_count == '0);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_echo_checker.sv
// Self-checking bench for uart_echo_checker with a behavioural far-end echo.
module tb_uart_echo_checker;

  localparam int NB = 16;
  localparam int TO = 1000;
`ifdef UART_ECHO_LFSR_EN
  localparam logic [7:0] SEED = 8'h00;
`else
  localparam logic [7:0] SEED = 8'hF8;
`endif

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  tx_byte;
  logic        transmit;
  logic        is_transmitting;
  logic [7:0]  rx_byte;
  logic        received;
  logic        busy;
  logic        done;
  logic        pass;
  logic [7:0]  err_count;
  logic [15:0] bytes_done;

  uart_echo_checker #(
    .NUM_BYTES      (NB),
    .TIMEOUT_CYCLES (TO),
    .SEED           (SEED)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .tx_byte         (tx_byte),
    .transmit        (transmit),
    .is_transmitting (is_transmitting),
    .rx_byte         (rx_byte),
    .received        (received),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .err_count       (err_count),
    .bytes_done      (bytes_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // i-th byte of a run, straight from the pattern definition
  function automatic logic [7:0] exp_pat(input int i);
    logic [7:0] p;
`ifdef UART_ECHO_LFSR_EN
    p = (SEED == 8'h00) ? 8'h01 : SEED;
    for (int k = 0; k < i; k++) p = {p[6:0], p[7] ^ p[5] ^ p[4] ^ p[3]};
`else
    p = 8'(int'(SEED) + i);
`endif
    return p;
  endfunction

  typedef struct {
    int         at;
    logic [7:0] b;
  } ev_t;

  ev_t        evq[$];
  int         corrupt_idx = -1;
  int         drop_idx    = -1;
  bit         hold_it     = 1'b0;
  int         it_until    = -1;
  int         sent_idx    = 0;
  int         exp_err     = 0;
  int         done_cnt    = 0;
  int         tx_cyc[NB];
  logic [7:0] tx_log[NB];

  // Per-cycle compare against the model, then far-end echo stimulus
  initial begin
    received        = 1'b0;
    rx_byte         = 8'h00;
    is_transmitting = 1'b0;
    forever begin
      @(negedge clk);
      if (transmit) begin
        chk("tx_line_idle", is_transmitting, 0);
        chk("busy_at_tx", busy, 1);
        if (sent_idx < NB) begin
          chk("tx_byte", tx_byte, exp_pat(sent_idx));
          tx_log[sent_idx] = tx_byte;
          tx_cyc[sent_idx] = cyc;
        end else begin
          chk("extra_tx", sent_idx, NB - 1);
        end
        if (sent_idx == drop_idx) begin
          exp_err++;
          evq.push_back('{cyc + 1002, tx_byte});
        end else if (sent_idx == corrupt_idx) begin
          exp_err++;
          evq.push_back('{cyc + 100, tx_byte ^ 8'h01});
        end else begin
          evq.push_back('{cyc + 100, tx_byte});
        end
        if (hold_it) it_until = cyc + 499;
        sent_idx++;
      end else if (rst_n && sent_idx > 0 && sent_idx <= NB) begin
        chk("tx_hold", tx_byte, exp_pat(sent_idx - 1));
      end
      if (done) begin
        done_cnt++;
        chk("done_err", err_count, exp_err);
        chk("done_bytes", bytes_done, NB);
        chk("done_sent", sent_idx, NB);
      end
      received = 1'b0;
      while (evq.size() > 0 && evq[0].at < cyc) void'(evq.pop_front());
      if (evq.size() > 0 && evq[0].at == cyc) begin
        received = 1'b1;
        rx_byte  = evq[0].b;
        void'(evq.pop_front());
      end
      is_transmitting = (cyc <= it_until);
    end
  end

  task automatic start_run(input int c, input int d, input bit h, output int start_c);
    corrupt_idx = c;
    drop_idx    = d;
    hold_it     = h;
    sent_idx    = 0;
    exp_err     = 0;
    @(negedge clk);
    start   = 1'b1;
    start_c = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    int n = 0;
    while (done_cnt == d0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", done_cnt, d0 + 1);
    @(negedge clk);
    chk("pass", pass, (exp_err == 0));
    chk("busy_after", busy, 0);
    chk("bytes_after", bytes_done, NB);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_tx_byte"}, tx_byte, 0);
    chk({tag, "_transmit"}, transmit, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_err"}, err_count, 0);
    chk({tag, "_bytes"}, bytes_done, 0);
  endtask

  initial begin
    int sc;
    int d0;
    int n;
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // clean loopback
    d0 = done_cnt;
    start_run(-1, -1, 1'b0, sc);
    wait_done(d0);
    chk("start_to_tx", tx_cyc[0] - sc, 2);
    chk("echo_gap", tx_cyc[1] - tx_cyc[0], 103);
`ifdef UART_ECHO_LFSR_EN
    chk("lfsr_b0", tx_log[0], 8'h01);
    chk("lfsr_b1", tx_log[1], 8'h02);
    chk("lfsr_b2", tx_log[2], 8'h04);
    chk("lfsr_b3", tx_log[3], 8'h08);
    chk("lfsr_b4", tx_log[4], 8'h11);
`else
    chk("cnt_b0", tx_log[0], 8'hF8);
    chk("cnt_b7", tx_log[7], 8'hFF);
    chk("cnt_b8", tx_log[8], 8'h00);
    chk("cnt_b15", tx_log[15], 8'h07);
`endif
    chk("clean_err", err_count, 0);

    // third echo corrupted
    d0 = done_cnt;
    start_run(2, -1, 1'b0, sc);
    wait_done(d0);
    chk("corrupt_err", err_count, 1);
    chk("corrupt_pass", pass, 0);

    // fifth echo dropped, late stray echo in WAIT_IDLE
    d0 = done_cnt;
    start_run(-1, 4, 1'b0, sc);
    wait_done(d0);
    chk("timeout_gap", tx_cyc[5] - tx_cyc[4], TO + 3);
    chk("drop_err", err_count, 1);

    // transmitter busy after each send, plus a start while busy
    d0 = done_cnt;
    start_run(-1, -1, 1'b1, sc);
    repeat (300) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(d0);
    for (int i = 1; i < NB; i++) chk("hold_gap", tx_cyc[i] - tx_cyc[i-1], 501);
    hold_it = 1'b0;
    repeat (600) @(negedge clk);
    chk("single_done", done_cnt, d0 + 1);
    chk("no_restart", sent_idx, NB);

    // reset mid-run after byte 7, with an error already recorded
    d0 = done_cnt;
    start_run(0, -1, 1'b0, sc);
    n = 0;
    while (bytes_done != 16'd7 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("reach_byte7", bytes_done, 7);
    chk("pre_reset_err", err_count, 1);
    rst_n       = 1'b0;
    sent_idx    = 0;
    exp_err     = 0;
    corrupt_idx = -1;
    #1;
    chk_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (300) @(negedge clk);
    chk("no_done_abort", done_cnt, d0);
    d0 = done_cnt;
    start_run(-1, -1, 1'b0, sc);
    wait_done(d0);
    chk("restart_b0", tx_log[0], exp_pat(0));
`ifdef UART_ECHO_LFSR_EN
    chk("restart_lit", tx_log[0], 8'h01);
`else
    chk("restart_lit", tx_log[0], 8'hF8);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
